fwft_prefetch_pipe: RTL

//  Generic first-word-fall-through (FWFT) read-side front end for any standard-mode FIFO core with
//  a fixed read latency of FIFO_LATENCY (1..4) cycles. It prefetches words into a small register

---
 rtl/fwft_prefetch_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fwft_prefetch_pipe.sv
// First-word-fall-through read front end for a fixed-latency standard-mode FIFO core.
// Prefetches into a register skid buffer and presents a registered dout/empty interface.
module fwft_prefetch_pipe #(
  parameter int unsigned DELAY        = 1,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned FIFO_LATENCY = 1,
  parameter int unsigned EXTRA_DEPTH  = 0,
  localparam int unsigned DEPTH       = FIFO_LATENCY + 1 + EXTRA_DEPTH
) (
  input  logic                       RD_CLK,
  input  logic                       RESET,
  input  logic                       fifo_empty,
  output logic                       fifo_rden,
  input  logic [WIDTH-1:0]           fifo_dout,
  input  logic                       rden,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       underflow
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned SK = DEPTH - 1;
  localparam int unsigned PW = (SK > 1) ? $clog2(SK) : 1;
  localparam int unsigned IW = $clog2(FIFO_LATENCY + 1);
  localparam int unsigned CW = $clog2(DEPTH + FIFO_LATENCY + 1);

  // DELAY is accepted for drop-in compatibility; register updates here are zero-delay.
  if (FIFO_LATENCY < 1 || FIFO_LATENCY > 4 || EXTRA_DEPTH > 4 || DELAY > 1000) begin : g_bad_param
    $error("fwft_prefetch_pipe: parameter out of legal range");
  end

  logic [FIFO_LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]        skid_q [SK];
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]           skid_cnt_q, skid_cnt_d;
  logic [WIDTH-1:0]        dout_q, dout_d;
  logic                    empty_q, empty_d;
  logic                    underflow_q;
  logic                    pop, arrive, skid_we, skid_pop;
  logic [IW-1:0]           inflight;
  logic [CW-1:0]           credit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SK - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop       = rden & ~empty_q;
  assign level     = skid_cnt_q + {{(LW-1){1'b0}}, ~empty_q};
  assign inflight  = IW'($countones(vld_q));
  assign credit    = CW'(level) + CW'(inflight) - CW'(pop);
  assign fifo_rden = ~fifo_empty & ~flush & ~RESET & (credit < CW'(DEPTH));
  assign arrive    = vld_q[FIFO_LATENCY-1] & ~flush;

  assign dout      = dout_q;
  assign empty     = empty_q;
  assign underflow = underflow_q;

  always_comb begin
    vld_d      = flush ? '0 : ((vld_q << 1) | FIFO_LATENCY'(fifo_rden));
    dout_d     = dout_q;
    empty_d    = empty_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    skid_cnt_d = skid_cnt_q;
    skid_we    = 1'b0;
    skid_pop   = 1'b0;
    if (flush) begin
      empty_d    = 1'b1;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      skid_cnt_d = '0;
    end else begin
      if (pop) begin
        if (skid_cnt_q != '0) begin
          dout_d   = skid_q[rd_ptr_q];
          rd_ptr_d = ptr_inc(rd_ptr_q);
          skid_pop = 1'b1;
        end else if (arrive) begin
          dout_d = fifo_dout;
        end else begin
          empty_d = 1'b1;
        end
      end else if (arrive && empty_q) begin
        dout_d  = fifo_dout;
        empty_d = 1'b0;
      end
      // A returning word bypasses the skid only when nothing older is queued ahead of it.
      skid_we    = arrive & ~((pop | empty_q) & (skid_cnt_q == '0));
      if (skid_we) wr_ptr_d = ptr_inc(wr_ptr_q);
      skid_cnt_d = skid_cnt_q + LW'(skid_we) - LW'(skid_pop);
    end
  end

  always_ff @(posedge RD_CLK) begin
    if (RESET) begin
      vld_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      skid_cnt_q  <= '0;
      dout_q      <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
      for (int unsigned i = 0; i < SK; i++) skid_q[i] <= '0;
    end else begin
      vld_q       <= vld_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      skid_cnt_q  <= skid_cnt_d;
      dout_q      <= dout_d;
      empty_q     <= empty_d;
      underflow_q <= rden & empty_q;
      if (skid_we) skid_q[wr_ptr_q] <= fifo_dout;
    end
  end

  a_no_overflow: assert property (@(posedge RD_CLK) disable iff (RESET)
    !(arrive && (level == LW'(DEPTH))));

endmodule
